// File: rtl/t08_pkg.sv
// Shared definitions for the team-08 Wishbone arbiter.
//   arb_state_t : arbiter FSM state encoding
//   WB_DW       : Wishbone data/address width
//   REQ_*       : fixed requester slot assignment
package t08_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int WB_DW = 32;

    localparam int REQ_IFETCH = 0;
    localparam int REQ_DATA   = 1;
    localparam int REQ_DISP   = 2;

endpackage

// File: rtl/t08_rr_picker.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index holding highest priority this round
//   gnt_o   : one-hot winner (zero when nothing requests)
//   idx_o   : binary index of the winner
//   valid_o : a winner exists
module t08_rr_picker
    import t08_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    // Two passes: first the slots at or above the pointer, then wrap around
    // to the slots below it. The first hit in scan order wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!valid_o && req_i[k] && (k >= int'(ptr_i))) begin
                gnt_o[k] = 1'b1;
                idx_o    = PTR_W'(k);
                valid_o  = 1'b1;
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!valid_o && req_i[k]) begin
                gnt_o[k] = 1'b1;
                idx_o    = PTR_W'(k);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/t08_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic master port between
// N_REQ requesters, with a bounded ack timeout.
//   clk, nRst          : clock, synchronous active-low reset
//   req_*_i            : per-requester request level and access fields
//   done_o / err_o     : one-cycle completion / timeout pulse per requester
//   rdat_o             : read data, valid while a done_o bit is high
//   gnt_o              : one-hot grant for the whole bus cycle
//   wb_*               : Wishbone classic single-beat master port
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the winner's fields
// BUS   | Wishbone cycle open, waiting for ack or timeout
// DONE  | done/err pulse visible for one cycle, grant released
module t08_wb_arbiter
    import t08_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   nRst,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ-1:0]       req_we_i,
    input  logic [4*N_REQ-1:0]     req_sel_i,
    input  logic [WB_DW*N_REQ-1:0] req_adr_i,
    input  logic [WB_DW*N_REQ-1:0] req_dat_i,
    output logic [N_REQ-1:0]       done_o,
    output logic [N_REQ-1:0]       err_o,
    output logic [WB_DW-1:0]       rdat_o,
    output logic [N_REQ-1:0]       gnt_o,
    input  logic [WB_DW-1:0]       wb_dat_i,
    input  logic                   wb_ack_i,
    output logic [WB_DW-1:0]       wb_adr_o,
    output logic [WB_DW-1:0]       wb_dat_o,
    output logic [3:0]             wb_sel_o,
    output logic                   wb_we_o,
    output logic                   wb_stb_o,
    output logic                   wb_cyc_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state_q;
    logic [PTR_W-1:0] ptr_q, ptr_d, win_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, done_q, err_q;
    logic [WB_DW-1:0] rdat_q, adr_q, dat_q;
    logic [3:0]       sel_q;
    logic             we_q, cyc_q, stb_q;

    logic [N_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_valid;
    logic [WB_DW-1:0] adr_mux, dat_mux;
    logic [3:0]       sel_mux;
    logic             we_mux;
    logic             timeout_hit;

    t08_rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        adr_mux = '0;
        dat_mux = '0;
        sel_mux = '0;
        we_mux  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_gnt[k]) begin
                adr_mux = req_adr_i[WB_DW*k +: WB_DW];
                dat_mux = req_dat_i[WB_DW*k +: WB_DW];
                sel_mux = req_sel_i[4*k +: 4];
                we_mux  = req_we_i[k];
            end
        end
    end

    assign ptr_d = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);
    assign cnt_d = cnt_q + CNT_W'(1);
    // cnt_q counts completed BUS cycles, so the cycle in which cnt_d reaches
    // TIMEOUT is the last one the slave gets; ack in that cycle still wins.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q <= IDLE;
            ptr_q   <= PTR_W'(REQ_IFETCH);
            win_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdat_q  <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        adr_q   <= adr_mux;
                        dat_q   <= dat_mux;
                        sel_q   <= sel_mux;
                        we_q    <= we_mux;
                        gnt_q   <= pick_gnt;
                        win_q   <= pick_idx;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    cnt_q <= cnt_d;
                    if (wb_ack_i) begin
                        rdat_q  <= wb_dat_i;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        done_q  <= gnt_q;
                        ptr_q   <= ptr_d;
                        state_q <= DONE;
                    end else if (timeout_hit) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        err_q   <= gnt_q;
                        ptr_q   <= ptr_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= '0;
                    err_q   <= '0;
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done_o   = done_q;
    assign err_o    = err_q;
    assign rdat_o   = rdat_q;
    assign gnt_o    = gnt_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_stb_o = stb_q;
    assign wb_cyc_o = cyc_q;

endmodule

// File: tb/tb_t08_wb_arbiter.sv
module tb_t08_wb_arbiter;
    import t08_pkg::*;

    localparam int N = 3;

    logic            clk;
    logic            nRst;
    logic [N-1:0]    req_i, req_we_i;
    logic [4*N-1:0]  req_sel_i;
    logic [32*N-1:0] req_adr_i, req_dat_i;
    logic [N-1:0]    done_o, err_o, gnt_o;
    logic [31:0]     rdat_o, wb_dat_i, wb_adr_o, wb_dat_o;
    logic            wb_ack_i, wb_we_o, wb_stb_o, wb_cyc_o;
    logic [3:0]      wb_sel_o;

    t08_wb_arbiter #(.N_REQ(N), .TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .nRst(nRst),
        .req_i(req_i), .req_we_i(req_we_i), .req_sel_i(req_sel_i),
        .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
        .done_o(done_o), .err_o(err_o), .rdat_o(rdat_o), .gnt_o(gnt_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o)
    );

    // picker unit under table-driven test
    logic [2:0] pk_req, pk_gnt;
    logic [1:0] pk_ptr, pk_idx;
    logic       pk_valid;
    t08_rr_picker #(.N_REQ(3), .PTR_W(2)) u_pk (
        .req_i(pk_req), .ptr_i(pk_ptr), .gnt_o(pk_gnt), .idx_o(pk_idx), .valid_o(pk_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- SRAM slave model ----------------
    logic [31:0] mem [64];
    int          bus_cnt = 0;
    int          ack_lat = 0;
    bit          ack_en = 1'b1;
    bit          stray_ack = 1'b0;
    bit          pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;

    assign wb_ack_i = (wb_cyc_o && wb_stb_o && ack_en && (bus_cnt == ack_lat)) || stray_ack;
    assign wb_dat_i = mem[wb_adr_o[7:2]];

    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && !wb_ack_i) bus_cnt <= bus_cnt + 1;
        else                                   bus_cnt <= 0;
        if (pl_en) mem[pl_idx] <= pl_dat;
        else if (wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o)
            for (int b = 0; b < 4; b++)
                if (wb_sel_o[b]) mem[wb_adr_o[7:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
    end

    task automatic preload(input logic [31:0] adr, input logic [31:0] dat);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = adr[7:2]; pl_dat = dat;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          idx;
        bit          err;
        bit          chk_rdat;
        logic [31:0] rdat;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic push(input int idx, input bit err, input bit chk_rd, input logic [31:0] rd);
        exp_t e;
        e.idx = idx; e.err = err; e.chk_rdat = chk_rd; e.rdat = rd;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        n_checks++;
        if (!$onehot0(gnt_o)) begin
            n_fail++;
            $display("FAIL gnt_onehot actual=%b required=onehot0 t=%0t", gnt_o, $time);
        end
        if ((done_o | err_o) != '0) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_completion done=%b err=%b required=none t=%0t", done_o, err_o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_done", 32'(done_o), mon_e.err ? 32'd0 : 32'(3'b001 << mon_e.idx));
                chk("sb_err",  32'(err_o),  mon_e.err ? 32'(3'b001 << mon_e.idx) : 32'd0);
                if (mon_e.chk_rdat) chk("sb_rdat", rdat_o, mon_e.rdat);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_fields(input int k, input bit we, input logic [3:0] sel,
                              input logic [31:0] adr, input logic [31:0] dat);
        req_we_i[k]           = we;
        req_sel_i[4*k +: 4]   = sel;
        req_adr_i[32*k +: 32] = adr;
        req_dat_i[32*k +: 32] = dat;
    endtask

    // Waits for a done/err pulse; returns negedges waited and how many of
    // them saw cyc high. Expiry counts as a failure.
    task automatic wait_cmpl(input int max, output int n, output int ncyc);
        n = 0; ncyc = 0;
        forever begin
            @(negedge clk);
            n++;
            if (wb_cyc_o) ncyc++;
            if ((done_o | err_o) != '0) return;
            if (n >= max) begin
                n_checks++; n_fail++;
                $display("FAIL wait_timeout actual=%0d cycles required=completion t=%0t", n, $time);
                return;
            end
        end
    endtask

    task automatic access(input int k, input bit we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat,
                          input bit err, input bit chk_rd, input logic [31:0] rd,
                          output int ncyc);
        int n;
        set_fields(k, we, sel, adr, dat);
        push(k, err, chk_rd, rd);
        req_i[k] = 1'b1;
        wait_cmpl(60, n, ncyc);
        req_i[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); nRst = 1'b0;
        @(negedge clk);
        @(negedge clk); nRst = 1'b1;
    endtask

    // ---------------- picker vectors ----------------
    typedef struct {
        logic [2:0] req;
        logic [1:0] ptr;
        logic [2:0] gnt;
        logic [1:0] idx;
        logic       valid;
    } pk_vec_t;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        pk_vec_t vec [12];
        int n, nc;

        vec[0]  = '{3'b000, 2'd0, 3'b000, 2'd0, 1'b0};
        vec[1]  = '{3'b111, 2'd0, 3'b001, 2'd0, 1'b1};
        vec[2]  = '{3'b111, 2'd1, 3'b010, 2'd1, 1'b1};
        vec[3]  = '{3'b111, 2'd2, 3'b100, 2'd2, 1'b1};
        vec[4]  = '{3'b101, 2'd1, 3'b100, 2'd2, 1'b1};
        vec[5]  = '{3'b011, 2'd2, 3'b001, 2'd0, 1'b1};
        vec[6]  = '{3'b110, 2'd0, 3'b010, 2'd1, 1'b1};
        vec[7]  = '{3'b001, 2'd2, 3'b001, 2'd0, 1'b1};
        vec[8]  = '{3'b010, 2'd0, 3'b010, 2'd1, 1'b1};
        vec[9]  = '{3'b100, 2'd1, 3'b100, 2'd2, 1'b1};
        vec[10] = '{3'b011, 2'd1, 3'b010, 2'd1, 1'b1};
        vec[11] = '{3'b000, 2'd2, 3'b000, 2'd0, 1'b0};

        nRst = 1'b0;
        req_i = '0; req_we_i = '0; req_sel_i = '0; req_adr_i = '0; req_dat_i = '0;
        pk_req = '0; pk_ptr = '0;

        for (int i = 0; i < 12; i++) begin
            pk_req = vec[i].req; pk_ptr = vec[i].ptr;
            #1;
            chk($sformatf("pick_gnt[%0d]", i), 32'(pk_gnt), 32'(vec[i].gnt));
            chk($sformatf("pick_valid[%0d]", i), 32'(pk_valid), 32'(vec[i].valid));
            if (vec[i].valid) chk($sformatf("pick_idx[%0d]", i), 32'(pk_idx), 32'(vec[i].idx));
        end

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_cyc", 32'(wb_cyc_o), 0);
        chk("rst_stb", 32'(wb_stb_o), 0);
        chk("rst_we",  32'(wb_we_o), 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_sel", 32'(wb_sel_o), 0);
        chk("rst_gnt", 32'(gnt_o), 0);
        chk("rst_done", 32'(done_o | err_o), 0);
        chk("rst_rdat", rdat_o, 0);
        nRst = 1'b1;

        preload(32'h3300_0010, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) preload(32'h3300_0040 + 32'(4*k), 32'h1111_0000 + 32'(k));

        // single read, zero-wait slave
        set_fields(REQ_IFETCH, 1'b0, 4'hF, 32'h3300_0010, 32'h0);
        push(REQ_IFETCH, 1'b0, 1'b1, 32'hDEAD_BEEF);
        req_i = 3'b001;
        @(negedge clk);
        chk("rd_cyc", 32'(wb_cyc_o), 1);
        chk("rd_stb", 32'(wb_stb_o), 1);
        chk("rd_adr", wb_adr_o, 32'h3300_0010);
        chk("rd_we",  32'(wb_we_o), 0);
        chk("rd_gnt", 32'(gnt_o), 32'b001);
        wait_cmpl(20, n, nc);
        req_i = '0;
        @(negedge clk);
        chk("rd_done_width", 32'(done_o), 0);
        chk("rd_gnt_clear", 32'(gnt_o), 0);
        chk("rd_rdat_hold", rdat_o, 32'hDEAD_BEEF);

        // write / read-back / partial write
        access(REQ_DATA, 1'b1, 4'b1111, 32'h3300_0020, 32'hA5A5_1234, 1'b0, 1'b0, 32'h0, nc);
        access(REQ_DATA, 1'b0, 4'b1111, 32'h3300_0020, 32'h0, 1'b0, 1'b1, 32'hA5A5_1234, nc);
        access(REQ_DATA, 1'b1, 4'b0011, 32'h3300_0020, 32'hFFFF_0000, 1'b0, 1'b0, 32'h0, nc);
        access(REQ_DATA, 1'b0, 4'b1111, 32'h3300_0020, 32'h0, 1'b0, 1'b1, 32'hA5A5_0000, nc);

        // contention from reset pointer: 0,1,2 repeating, one transfer per 3 cycles
        do_reset();
        for (int k = 0; k < 3; k++) set_fields(k, 1'b0, 4'hF, 32'h3300_0040 + 32'(4*k), 32'h0);
        for (int i = 0; i < 9; i++) push(i % 3, 1'b0, 1'b1, 32'h1111_0000 + 32'(i % 3));
        req_i = 3'b111;
        for (int i = 0; i < 9; i++) begin
            wait_cmpl(20, n, nc);
            if (i > 0) chk("rr_interval", 32'(n), 3);
            if (i == 8) req_i = '0;
        end
        @(negedge clk);

        // timeout: no ack, bus held 8 cycles, then err
        ack_en = 1'b0;
        access(REQ_DISP, 1'b0, 4'hF, 32'h3300_0050, 32'h0, 1'b1, 1'b0, 32'h0, nc);
        chk("to_cyc_cycles", 32'(nc), 8);
        chk("to_idle_cyc", 32'(wb_cyc_o), 0);
        chk("to_idle_gnt", 32'(gnt_o), 0);
        ack_en = 1'b1;

        // ack in the timeout cycle wins
        ack_lat = 7;
        access(REQ_IFETCH, 1'b0, 4'hF, 32'h3300_0010, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, nc);
        chk("ack_vs_to_cycles", 32'(nc), 8);

        // stray ack while idle
        ack_lat = 0;
        stray_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_cyc", 32'(wb_cyc_o), 0);
        end
        stray_ack = 1'b0;
        chk("stray_rdat_hold", rdat_o, 32'hDEAD_BEEF);

        // reset during BUS cycle 5 with a slow slave
        ack_lat = 20;
        set_fields(REQ_DISP, 1'b0, 4'hF, 32'h3300_0048, 32'h0);
        set_fields(REQ_IFETCH, 1'b0, 4'hF, 32'h3300_0040, 32'h0);
        req_i = 3'b100;
        repeat (5) @(negedge clk);
        chk("mid_cyc_before", 32'(wb_cyc_o), 1);
        nRst = 1'b0;
        @(negedge clk);
        chk("mid_cyc_after", 32'(wb_cyc_o), 0);
        chk("mid_stb_after", 32'(wb_stb_o), 0);
        chk("mid_gnt_after", 32'(gnt_o), 0);
        chk("mid_no_pulse", 32'(done_o | err_o), 0);
        ack_lat = 0;
        req_i = 3'b101;
        push(REQ_IFETCH, 1'b0, 1'b1, 32'h1111_0000);
        push(REQ_DISP, 1'b0, 1'b1, 32'h1111_0002);
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", 32'(gnt_o), 32'b001);
        for (int i = 0; i < 2; i++) begin
            wait_cmpl(20, n, nc);
            req_i &= ~(done_o | err_o);
        end
        @(negedge clk);

        // withdrawal: pointer moved to 1 first
        access(REQ_IFETCH, 1'b0, 4'hF, 32'h3300_0040, 32'h0, 1'b0, 1'b1, 32'h1111_0000, nc);
        ack_lat = 3;
        set_fields(REQ_DATA, 1'b0, 4'hF, 32'h3300_0044, 32'h0);
        push(REQ_DATA, 1'b0, 1'b1, 32'h1111_0001);
        req_i = 3'b010;
        @(negedge clk);
        chk("wd_gnt", 32'(gnt_o), 32'b010);
        chk("wd_adr", wb_adr_o, 32'h3300_0044);
        set_fields(REQ_DATA, 1'b1, 4'hF, 32'h3300_0010, 32'h1234_5678);
        req_i = 3'b101;
        push(REQ_DISP, 1'b0, 1'b1, 32'h1111_0002);
        push(REQ_IFETCH, 1'b0, 1'b1, 32'h1111_0000);
        @(negedge clk);
        chk("wd_adr_latched", wb_adr_o, 32'h3300_0044);
        chk("wd_we_latched", 32'(wb_we_o), 0);
        for (int i = 0; i < 3; i++) begin
            wait_cmpl(20, n, nc);
            req_i &= ~(done_o | err_o);
        end
        @(negedge clk);

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
